// File: rtl/bc_io_ctrl_if.sv
// CPU-side and device-side signal bundle for the multi-channel I/O unit.
// The controller connects through the slave modport; the CPU/device side uses master.
interface bc_io_ctrl_if #(
    parameter int DW  = 8,
    parameter int NCH = 4,
    parameter int CHB = 2,
    parameter int AW  = 16
);
    logic [NCH*DW-1:0] dev_in_data;
    logic [NCH-1:0]    dev_in_valid;
    logic [NCH-1:0]    dev_in_ready;
    logic [NCH*DW-1:0] dev_out_data;
    logic [NCH-1:0]    dev_out_valid;
    logic [NCH-1:0]    dev_out_ready;
    logic [CHB-1:0]    io_sel;
    logic              inp_en;
    logic              out_en;
    logic [AW-1:0]     ac_in;
    logic              ion;
    logic              iof;
    logic              int_ack;
    logic              mask_we;
    logic [2*NCH-1:0]  mask_din;
    logic [DW-1:0]     inpr_out;
    logic              fgi_sel;
    logic              fgo_sel;
    logic              ien;
    logic              irq;
    logic [CHB-1:0]    irq_ch;
    logic [2*NCH-1:0]  imask;

    modport master (
        output dev_in_data, dev_in_valid, dev_out_ready, io_sel, inp_en, out_en,
               ac_in, ion, iof, int_ack, mask_we, mask_din,
        input  dev_in_ready, dev_out_data, dev_out_valid, inpr_out, fgi_sel,
               fgo_sel, ien, irq, irq_ch, imask
    );

    modport slave (
        input  dev_in_data, dev_in_valid, dev_out_ready, io_sel, inp_en, out_en,
               ac_in, ion, iof, int_ack, mask_we, mask_din,
        output dev_in_ready, dev_out_data, dev_out_valid, inpr_out, fgi_sel,
               fgo_sel, ien, irq, irq_ch, imask
    );
endinterface

// File: rtl/bc_io_ctrl.sv
// NCH INPR/OUTR channel pairs with FGI/FGO flags, masked interrupt request and IEN.
// Flag updates are visible one cycle after the edge; a full INPR / unsent OUTR stalls its device or drops the CPU write.
module bc_io_ctrl #(
    parameter int DW  = 8,
    parameter int NCH = 4,
    parameter int CHB = 2,
    parameter int AW  = 16
) (
    input  logic        clk,
    input  logic        rst,
    bc_io_ctrl_if.slave io
);
    logic [NCH-1:0]   fgi;
    logic [NCH-1:0]   fgo;
    logic [DW-1:0]    inpr [NCH];
    logic [DW-1:0]    outr [NCH];
    logic             ien;
    logic [2*NCH-1:0] imask;

    logic [NCH-1:0]   inp_hit;
    logic [NCH-1:0]   out_hit;
    logic [NCH-1:0]   pend;

    logic             unused_ac;
    assign unused_ac = ^io.ac_in[AW-1:DW];

    always_comb begin
        io.inpr_out      = '0;
        io.fgi_sel       = 1'b0;
        io.fgo_sel       = 1'b0;
        io.irq_ch        = '0;
        io.dev_out_data  = '0;
        inp_hit          = '0;
        out_hit          = '0;
        pend             = '0;
        // Out-of-range selects never match any channel, so they read as zero and are ignored.
        for (int i = 0; i < NCH; i++) begin
            io.dev_out_data[i*DW +: DW] = outr[i];
            pend[i] = (fgi[i] & imask[i]) | (fgo[i] & imask[NCH+i]);
            if (CHB'(i) == io.io_sel) begin
                io.inpr_out = inpr[i];
                io.fgi_sel  = fgi[i];
                io.fgo_sel  = fgo[i];
                inp_hit[i]  = io.inp_en;
                out_hit[i]  = io.out_en;
            end
        end
        for (int i = NCH-1; i >= 0; i--) begin
            if (pend[i]) io.irq_ch = CHB'(i);
        end
    end

    assign io.dev_in_ready  = ~fgi;
    assign io.dev_out_valid = ~fgo;
    assign io.ien           = ien;
    assign io.imask         = imask;
    assign io.irq           = ien & (|pend);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fgi   <= '0;
            fgo   <= '1;
            ien   <= 1'b0;
            imask <= '1;
            for (int i = 0; i < NCH; i++) begin
                inpr[i] <= '0;
                outr[i] <= '0;
            end
        end else begin
            // Capture needs FGI=0 and the CPU clear needs FGI=1, so the two never collide.
            for (int i = 0; i < NCH; i++) begin
                if (io.dev_in_valid[i] && !fgi[i]) begin
                    inpr[i] <= io.dev_in_data[i*DW +: DW];
                    fgi[i]  <= 1'b1;
                end else if (inp_hit[i] && fgi[i]) begin
                    fgi[i]  <= 1'b0;
                end
                if (out_hit[i] && fgo[i]) begin
                    outr[i] <= io.ac_in[DW-1:0];
                    fgo[i]  <= 1'b0;
                end else if (io.dev_out_ready[i] && !fgo[i]) begin
                    fgo[i]  <= 1'b1;
                end
            end
            if (io.int_ack || io.iof) begin
                ien <= 1'b0;
            end else if (io.ion) begin
                ien <= 1'b1;
            end
            if (io.mask_we) imask <= io.mask_din;
        end
    end
endmodule

// File: tb/tb_bc_io_ctrl.sv
// Directed bench for bc_io_ctrl with default parameters (DW=8, NCH=4, CHB=2, AW=16).
module tb_bc_io_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    bc_io_ctrl_if #(.DW(8), .NCH(4), .CHB(2), .AW(16)) io ();

    bc_io_ctrl #(.DW(8), .NCH(4), .CHB(2), .AW(16)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        io.dev_in_data   = '0;
        io.dev_in_valid  = '0;
        io.dev_out_ready = '0;
        io.io_sel        = '0;
        io.inp_en        = 1'b0;
        io.out_en        = 1'b0;
        io.ac_in         = '0;
        io.ion           = 1'b0;
        io.iof           = 1'b0;
        io.int_ack       = 1'b0;
        io.mask_we       = 1'b0;
        io.mask_din      = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        tests++; if (io.dev_in_ready !== 4'hF) begin fails++; $display("FAIL rst_in_ready got %h want %h", io.dev_in_ready, 4'hF); end
        tests++; if (io.dev_out_valid !== 4'h0) begin fails++; $display("FAIL rst_out_valid got %h want %h", io.dev_out_valid, 4'h0); end
        tests++; if (io.ien !== 1'b0) begin fails++; $display("FAIL rst_ien got %b want 0", io.ien); end
        tests++; if (io.irq !== 1'b0) begin fails++; $display("FAIL rst_irq got %b want 0", io.irq); end
        tests++; if (io.irq_ch !== 2'd0) begin fails++; $display("FAIL rst_irq_ch got %0d want 0", io.irq_ch); end
        tests++; if (io.imask !== 8'hFF) begin fails++; $display("FAIL rst_imask got %h want ff", io.imask); end
        tests++; if (io.inpr_out !== 8'h00) begin fails++; $display("FAIL rst_inpr got %h want 00", io.inpr_out); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_input();
        io.dev_in_data[2*8 +: 8] = 8'h41;
        io.dev_in_valid = 4'b0100;
        tick();
        io.dev_in_valid = 4'b0000;
        io.io_sel = 2'd2;
        #1;
        tests++; if (io.dev_in_ready !== 4'b1011) begin fails++; $display("FAIL in_ready_full got %b want 1011", io.dev_in_ready); end
        tests++; if (io.fgi_sel !== 1'b1) begin fails++; $display("FAIL in_fgi_sel got %b want 1", io.fgi_sel); end
        tests++; if (io.inpr_out !== 8'h41) begin fails++; $display("FAIL in_inpr got %h want 41", io.inpr_out); end
        io.inp_en = 1'b1;
        tick();
        io.inp_en = 1'b0;
        tests++; if (io.fgi_sel !== 1'b0) begin fails++; $display("FAIL inp_clear got %b want 0", io.fgi_sel); end
        tests++; if (io.dev_in_ready !== 4'hF) begin fails++; $display("FAIL inp_ready got %b want 1111", io.dev_in_ready); end
        tests++; if (io.inpr_out !== 8'h41) begin fails++; $display("FAIL inp_retain got %h want 41", io.inpr_out); end
        // INP on an empty channel on the same edge as a device capture: flag must still set.
        io.io_sel = 2'd0;
        io.inp_en = 1'b1;
        io.dev_in_data[0 +: 8] = 8'h7E;
        io.dev_in_valid = 4'b0001;
        tick();
        io.inp_en = 1'b0;
        io.dev_in_valid = 4'b0000;
        tests++; if (io.dev_in_ready !== 4'b1110) begin fails++; $display("FAIL inp_same_edge got %b want 1110", io.dev_in_ready); end
        tests++; if (io.inpr_out !== 8'h7E) begin fails++; $display("FAIL inp_same_edge_dat got %h want 7e", io.inpr_out); end
        io.inp_en = 1'b1;
        tick();
        io.inp_en = 1'b0;
        tests++; if (io.dev_in_ready !== 4'hF) begin fails++; $display("FAIL inp_ch0_clear got %b want 1111", io.dev_in_ready); end
    endtask

    task automatic test_output();
        io.io_sel = 2'd1;
        io.ac_in  = 16'h1234;
        io.out_en = 1'b1;
        tick();
        tests++; if (io.dev_out_data[15:8] !== 8'h34) begin fails++; $display("FAIL out_data got %h want 34", io.dev_out_data[15:8]); end
        tests++; if (io.dev_out_valid !== 4'b0010) begin fails++; $display("FAIL out_valid got %b want 0010", io.dev_out_valid); end
        tests++; if (io.fgo_sel !== 1'b0) begin fails++; $display("FAIL out_fgo_sel got %b want 0", io.fgo_sel); end
        io.ac_in = 16'h0055;
        tick();
        io.out_en = 1'b0;
        tests++; if (io.dev_out_data[15:8] !== 8'h34) begin fails++; $display("FAIL out_drop got %h want 34", io.dev_out_data[15:8]); end
        io.dev_out_ready = 4'b0010;
        tick();
        io.dev_out_ready = 4'b0000;
        tests++; if (io.dev_out_valid !== 4'b0000) begin fails++; $display("FAIL out_drain got %b want 0000", io.dev_out_valid); end
        tests++; if (io.fgo_sel !== 1'b1) begin fails++; $display("FAIL out_fgo_set got %b want 1", io.fgo_sel); end
        tests++; if (io.dev_out_data[15:8] !== 8'h34) begin fails++; $display("FAIL out_retain got %h want 34", io.dev_out_data[15:8]); end
    endtask

    task automatic test_simultaneous();
        io.dev_in_data[0 +: 8] = 8'h5A;
        io.dev_in_valid = 4'b0001;
        tick();
        io.dev_in_valid = 4'b0000;
        io.io_sel = 2'd0;
        io.ac_in  = 16'hFF99;
        io.inp_en = 1'b1;
        io.out_en = 1'b1;
        tick();
        io.inp_en = 1'b0;
        io.out_en = 1'b0;
        tests++; if (io.dev_in_ready !== 4'hF) begin fails++; $display("FAIL sim_inp got %b want 1111", io.dev_in_ready); end
        tests++; if (io.dev_out_valid !== 4'b0001) begin fails++; $display("FAIL sim_out_valid got %b want 0001", io.dev_out_valid); end
        tests++; if (io.dev_out_data[7:0] !== 8'h99) begin fails++; $display("FAIL sim_out_data got %h want 99", io.dev_out_data[7:0]); end
        io.dev_out_ready = 4'b0001;
        tick();
        io.dev_out_ready = 4'b0000;
        tests++; if (io.dev_out_valid !== 4'b0000) begin fails++; $display("FAIL sim_drain got %b want 0000", io.dev_out_valid); end
    endtask

    task automatic test_irq_priority();
        for (int ch = 0; ch < 4; ch++) begin
            io.io_sel = ch[1:0];
            io.ac_in  = 16'h00A0 + 16'(ch);
            io.out_en = 1'b1;
            tick();
        end
        io.out_en = 1'b0;
        tests++; if (io.dev_out_valid !== 4'hF) begin fails++; $display("FAIL pri_fgo_clear got %b want 1111", io.dev_out_valid); end
        tests++; if (io.dev_out_data !== 32'hA3A2A1A0) begin fails++; $display("FAIL pri_outr got %h want a3a2a1a0", io.dev_out_data); end
        io.ion = 1'b1;
        tick();
        io.ion = 1'b0;
        tests++; if (io.ien !== 1'b1) begin fails++; $display("FAIL pri_ion got %b want 1", io.ien); end
        tests++; if (io.irq !== 1'b0) begin fails++; $display("FAIL pri_idle_irq got %b want 0", io.irq); end
        io.dev_in_data = 32'h33001100;
        io.dev_in_valid = 4'b1010;
        tick();
        io.dev_in_valid = 4'b0000;
        tests++; if (io.dev_in_ready !== 4'b0101) begin fails++; $display("FAIL pri_in_ready got %b want 0101", io.dev_in_ready); end
        tests++; if (io.irq !== 1'b1) begin fails++; $display("FAIL pri_irq got %b want 1", io.irq); end
        tests++; if (io.irq_ch !== 2'd1) begin fails++; $display("FAIL pri_irq_ch got %0d want 1", io.irq_ch); end
        io.int_ack = 1'b1;
        tick();
        io.int_ack = 1'b0;
        tests++; if (io.ien !== 1'b0) begin fails++; $display("FAIL ack_ien got %b want 0", io.ien); end
        tests++; if (io.irq !== 1'b0) begin fails++; $display("FAIL ack_irq got %b want 0", io.irq); end
        tests++; if (io.dev_in_ready !== 4'b0101) begin fails++; $display("FAIL ack_flags got %b want 0101", io.dev_in_ready); end
        io.ion = 1'b1;
        io.int_ack = 1'b1;
        tick();
        io.ion = 1'b0;
        io.int_ack = 1'b0;
        tests++; if (io.ien !== 1'b0) begin fails++; $display("FAIL ack_over_ion got %b want 0", io.ien); end
    endtask

    task automatic test_masking();
        io.ion = 1'b1;
        tick();
        io.ion = 1'b0;
        tests++; if (io.irq !== 1'b1) begin fails++; $display("FAIL msk_reen_irq got %b want 1", io.irq); end
        io.mask_we  = 1'b1;
        io.mask_din = 8'h08;
        #1;
        tests++; if (io.irq_ch !== 2'd1) begin fails++; $display("FAIL msk_not_yet got %0d want 1", io.irq_ch); end
        tick();
        tests++; if (io.imask !== 8'h08) begin fails++; $display("FAIL msk_imask got %h want 08", io.imask); end
        tests++; if (io.irq !== 1'b1) begin fails++; $display("FAIL msk_irq got %b want 1", io.irq); end
        tests++; if (io.irq_ch !== 2'd3) begin fails++; $display("FAIL msk_irq_ch got %0d want 3", io.irq_ch); end
        io.mask_din = 8'h00;
        tick();
        tests++; if (io.irq !== 1'b0) begin fails++; $display("FAIL msk_zero_irq got %b want 0", io.irq); end
        tests++; if (io.irq_ch !== 2'd0) begin fails++; $display("FAIL msk_zero_ch got %0d want 0", io.irq_ch); end
        io.mask_din = 8'h40;
        tick();
        io.mask_we = 1'b0;
        tests++; if (io.irq !== 1'b0) begin fails++; $display("FAIL msk_fgo_busy got %b want 0", io.irq); end
        io.dev_out_ready = 4'b0100;
        tick();
        io.dev_out_ready = 4'b0000;
        tests++; if (io.irq !== 1'b1) begin fails++; $display("FAIL msk_fgo_irq got %b want 1", io.irq); end
        tests++; if (io.irq_ch !== 2'd2) begin fails++; $display("FAIL msk_fgo_ch got %0d want 2", io.irq_ch); end
        io.ion = 1'b1;
        io.iof = 1'b1;
        tick();
        io.ion = 1'b0;
        io.iof = 1'b0;
        tests++; if (io.ien !== 1'b0) begin fails++; $display("FAIL iof_over_ion got %b want 0", io.ien); end
    endtask

    task automatic test_reset_mid();
        io.dev_in_data[0 +: 8] = 8'hC3;
        io.dev_in_valid = 4'b0001;
        io.ion = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        tests++; if (io.dev_out_valid !== 4'h0) begin fails++; $display("FAIL mid_async_valid got %b want 0000", io.dev_out_valid); end
        tests++; if (io.dev_in_ready !== 4'hF) begin fails++; $display("FAIL mid_async_ready got %b want 1111", io.dev_in_ready); end
        tests++; if (io.imask !== 8'hFF) begin fails++; $display("FAIL mid_imask got %h want ff", io.imask); end
        tick();
        io.dev_in_valid = 4'b0000;
        io.ion = 1'b0;
        rst = 1'b0;
        tick();
        tests++; if (io.dev_in_ready !== 4'hF) begin fails++; $display("FAIL mid_discard got %b want 1111", io.dev_in_ready); end
        tests++; if (io.dev_out_data !== 32'h0) begin fails++; $display("FAIL mid_outr got %h want 0", io.dev_out_data); end
        tests++; if (io.ien !== 1'b0) begin fails++; $display("FAIL mid_ien got %b want 0", io.ien); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_input();
        test_output();
        test_simultaneous();
        test_irq_priority();
        test_masking();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
